// File: rtl/spmv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : spmv_pkg                                                 |
// | Purpose  : Shared types and constants for the SpMV row interface.  |
// |            Values are complex Q16 (16 fractional bits) in 32-bit   |
// |            signed halves.                                          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package spmv_pkg;

  localparam int NNZ       = 4;   // nonzeros per matrix row (ELL width)
  localparam int Q_FRAC    = 16;  // fractional bits of each value half
  localparam int VAL_W     = 32;  // width of each value half
  localparam int COL_W_MAX = 16;  // widest column index carried in an entry

  // One complex Q16 value: imaginary half in the upper word.
  typedef struct packed {
    logic signed [VAL_W-1:0] i;
    logic signed [VAL_W-1:0] r;
  } cval_t;

  // One ELL entry: column index plus its complex value.
  typedef struct packed {
    logic [COL_W_MAX-1:0] col;
    cval_t                val;
  } ell_entry_t;

endpackage
`default_nettype wire

// File: rtl/row_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : row_store                                               |
// | Purpose  : {row, slot} addressed ELL matrix storage with a single  |
// |            write port and a 4-wide combinational row read.         |
// |            Contents are not reset so the array can map onto RAM.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module row_store
  import spmv_pkg::*;
#(
  parameter  int MAT_RANK = 256,
  localparam int IDX_W    = $clog2(MAT_RANK)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_row,
  input  logic [1:0]               wr_slot,
  input  logic [IDX_W-1:0]         wr_col,
  input  cval_t                    wr_val,
  input  logic [IDX_W-1:0]         rd_row,
  output logic [NNZ*IDX_W-1:0]     rd_col,
  output cval_t [NNZ-1:0]          rd_val
);

  localparam int DEPTH  = MAT_RANK * NNZ;
  localparam int ADDR_W = IDX_W + 2;

  logic [IDX_W-1:0]  r_col_mem [DEPTH];
  cval_t             r_val_mem [DEPTH];
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_wr_addr = {wr_row, wr_slot};

  // Write one entry per clock; the caller gates wr_en while streaming.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_col_mem[w_wr_addr] <= wr_col;
      r_val_mem[w_wr_addr] <= wr_val;
    end
  end

  // Every slot of the addressed row is read in parallel.
  generate
    for (genvar k = 0; k < NNZ; k++) begin : g_rd_slot
      logic [ADDR_W-1:0] w_rd_addr;
      assign w_rd_addr                 = {rd_row, 2'(k)};
      assign rd_col[k*IDX_W +: IDX_W]  = r_col_mem[w_rd_addr];
      assign rd_val[k]                 = r_val_mem[w_rd_addr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/spmv_row_sender.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : spmv_row_sender                                         |
// | Purpose  : Streams a preloaded 4-nonzeros-per-row ELL matrix, one  |
// |            row per beat, over a valid/ready link to the SpMV       |
// |            multiplier. A registered output slice gives 1 row/cycle |
// |            with no combinational ready-to-valid path.              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module spmv_row_sender
  import spmv_pkg::*;
#(
  parameter  int MAT_RANK = 256,
  localparam int IDX_W    = $clog2(MAT_RANK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_row,
  input  logic [1:0]            wr_slot,
  input  logic [IDX_W-1:0]      wr_col,
  input  logic [31:0]           wr_val_i,
  input  logic [31:0]           wr_val_r,
  output logic                  wr_err,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [NNZ*IDX_W-1:0]  Scol_index,
  output logic [31:0]           S_val_i0,
  output logic [31:0]           S_val_r0,
  output logic [31:0]           S_val_i1,
  output logic [31:0]           S_val_r1,
  output logic [31:0]           S_val_i2,
  output logic [31:0]           S_val_r2,
  output logic [31:0]           S_val_i3,
  output logic [31:0]           S_val_r3,
  output logic                  S_vld_o,
  input  logic                  S_rdy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra pointer bit so "all MAT_RANK rows issued" is representable.
  localparam logic [IDX_W:0] c_rows = (IDX_W+1)'(MAT_RANK);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W:0]       r_ptr;
  logic                 w_more;
  logic                 w_load;
  logic                 w_last_accept;
  logic                 w_store_we;
  cval_t                w_wr_val;
  logic [NNZ*IDX_W-1:0] w_rd_col;
  cval_t [NNZ-1:0]      w_rd_val;

  assign w_wr_val   = {wr_val_i, wr_val_r};
  assign w_store_we = wr_en && (r_state != ST_SEND);
  assign busy       = (r_state == ST_SEND);
  assign done       = (r_state == ST_DONE);

  row_store #(
    .MAT_RANK (MAT_RANK)
  ) u_row_store (
    .clk    (clk),
    .wr_en  (w_store_we),
    .wr_row (wr_row),
    .wr_slot(wr_slot),
    .wr_col (wr_col),
    .wr_val (w_wr_val),
    .rd_row (r_ptr[IDX_W-1:0]),
    .rd_col (w_rd_col),
    .rd_val (w_rd_val)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus slice load / final-acceptance decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_more        = (r_ptr < c_rows);
    w_load        = 1'b0;
    w_last_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_load        = (!S_vld_o || S_rdy_o) && w_more;
        w_last_accept = S_vld_o && S_rdy_o && !w_more;
        if (w_last_accept) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // A start here chains straight into the next run.
        w_state_nxt = start ? ST_SEND : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Row pointer: cleared on an accepted start, advanced on each slice load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_ptr <= '0;
    else if (start && r_state != ST_SEND)   r_ptr <= '0;
    else if (w_load)                        r_ptr <= r_ptr + (IDX_W+1)'(1);
  end

  // Output slice: capture a row when empty or being drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_vld_o    <= 1'b0;
      Scol_index <= '0;
      S_val_i0   <= '0;
      S_val_r0   <= '0;
      S_val_i1   <= '0;
      S_val_r1   <= '0;
      S_val_i2   <= '0;
      S_val_r2   <= '0;
      S_val_i3   <= '0;
      S_val_r3   <= '0;
    end else if (w_load) begin
      S_vld_o    <= 1'b1;
      Scol_index <= w_rd_col;
      S_val_i0   <= w_rd_val[0].i;
      S_val_r0   <= w_rd_val[0].r;
      S_val_i1   <= w_rd_val[1].i;
      S_val_r1   <= w_rd_val[1].r;
      S_val_i2   <= w_rd_val[2].i;
      S_val_r2   <= w_rd_val[2].r;
      S_val_i3   <= w_rd_val[3].i;
      S_val_r3   <= w_rd_val[3].r;
    end else if (w_last_accept) begin
      S_vld_o    <= 1'b0;
    end
  end

  // Writes attempted mid-stream are dropped and flagged one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= wr_en && (r_state == ST_SEND);
  end

endmodule
`default_nettype wire
